// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: state encoding and PC width.
// Optional perf counters in fetch_ctrl are enabled by FETCH_PERF_EN.
package fetch_pkg;

    localparam int PC_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fetch_state_e;

    typedef logic [PC_W-1:0] pc_t;

endpackage

// File: rtl/fetch_if.sv
// Host-side bundle of fetch_ctrl: start/done handshake, branch inputs, PC out.
// Perf counter signals exist only when FETCH_PERF_EN is defined.
interface fetch_if #(
    parameter int D      = 12,
    parameter int PERF_W = 16
);
    logic         start;
    logic [D-1:0] start_pc;
    logic         stall;
    logic         halt;
    logic         branch_taken;
    logic         branch_rel;
    logic [D-1:0] target;
    logic [D-1:0] pc;
    logic         fetch_valid;
    logic         done;
`ifdef FETCH_PERF_EN
    logic [PERF_W-1:0] instr_count;
    logic [PERF_W-1:0] branch_count;
`endif

    modport master (
        output start, start_pc, stall, halt,
        output branch_taken, branch_rel, target,
`ifdef FETCH_PERF_EN
        input  instr_count, branch_count,
`endif
        input  pc, fetch_valid, done
    );

    modport slave (
        input  start, start_pc, stall, halt,
        input  branch_taken, branch_rel, target,
`ifdef FETCH_PERF_EN
        output instr_count, branch_count,
`endif
        output pc, fetch_valid, done
    );

endinterface

// File: rtl/fetch_ctrl_pc_next.sv
// Next-PC selection: sequential, absolute branch or relative branch,
// all modulo 2**D (relative offsets are two's complement).
module pc_next #(
    parameter int D = 12
) (
    input  logic [D-1:0] i_pc,
    input  logic [D-1:0] i_target,
    input  logic         i_branch_taken,
    input  logic         i_branch_rel,
    output logic [D-1:0] o_next_pc
);

    always_comb begin
        o_next_pc = i_pc + D'(1);
        unique case (1'b1)
            i_branch_taken &  i_branch_rel: o_next_pc = i_pc + i_target;
            i_branch_taken & ~i_branch_rel: o_next_pc = i_target;
            default:                        o_next_pc = i_pc + D'(1);
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// PC / fetch sequencer with IDLE-RUN-DONE run bracketing.
// Define FETCH_PERF_EN to add saturating instruction/branch counters.
import fetch_pkg::*;

module fetch_ctrl #(
    parameter int D      = PC_W,
    parameter int PERF_W = 16
) (
    input  logic   clk,
    input  logic   reset,
    fetch_if.slave bus
);

    fetch_state_e r_state;
    logic [D-1:0] r_pc;
    logic [D-1:0] w_next_pc;

    pc_next #(.D(D)) u_pc_next (
        .i_pc           (r_pc),
        .i_target       (bus.target),
        .i_branch_taken (bus.branch_taken),
        .i_branch_rel   (bus.branch_rel),
        .o_next_pc      (w_next_pc)
    );

    // Stall beats halt beats branch; halt keeps the halt address in pc.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state <= RUN;
                        r_pc    <= bus.start_pc;
                    end
                end
                RUN: begin
                    if (!bus.stall) begin
                        if (bus.halt) r_state <= DONE;
                        else          r_pc    <= w_next_pc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_pc    <= '0;
                end
            endcase
        end
    end

    assign bus.pc          = r_pc;
    assign bus.fetch_valid = (r_state == RUN);
    assign bus.done        = (r_state == DONE);

`ifdef FETCH_PERF_EN
    logic [PERF_W-1:0] r_instr_cnt;
    logic [PERF_W-1:0] r_branch_cnt;
    logic              w_adv;
    logic              w_take;
    logic              w_clr;

    assign w_adv  = (r_state == RUN) && !bus.stall;
    assign w_take = w_adv && !bus.halt && bus.branch_taken;
    assign w_clr  = (r_state != RUN) && bus.start;

    always_ff @(posedge clk) begin
        if (reset || w_clr) begin
            r_instr_cnt  <= '0;
            r_branch_cnt <= '0;
        end else begin
            if (w_adv && !(&r_instr_cnt))
                r_instr_cnt <= r_instr_cnt + PERF_W'(1);
            if (w_take && !(&r_branch_cnt))
                r_branch_cnt <= r_branch_cnt + PERF_W'(1);
        end
    end

    assign bus.instr_count  = r_instr_cnt;
    assign bus.branch_count = r_branch_cnt;
`endif

endmodule
